// File: rtl/clk_diag_responder_if.sv
// EBUS diagnostic-function handshake between the front end and the CLK board.
// ds and ebusData keep the EBUS big-endian numbering: bit 0 is the MSB.
interface clk_diag_responder_if;
  logic        diagStrobe;
  logic [0:6]  ds;
  logic [0:35] ebusData;
  logic        funcAck;
  logic        funcIllegal;

  // Front end: issues function codes and load operands.
  modport master (
    output diagStrobe, ds, ebusData,
    input  funcAck, funcIllegal
  );

  // CLK board: decodes and acknowledges.
  modport slave (
    input  diagStrobe, ds, ebusData,
    output funcAck, funcIllegal
  );
endinterface

// File: rtl/clk_diag_responder.sv
// CLK-board diagnostic function responder: decodes EBUS diag functions 000-077
// and drives the EBOX clock enable plus the CLK control registers.
module clk_diag_responder #(
  parameter int unsigned BURST_W = 8,
  parameter int unsigned CDADR_W = 11
) (
  input  logic                clk,
  input  logic                CROBAR,
  clk_diag_responder_if.slave bus,
  output logic                clkEn,
  output logic                clkRun,
  output logic                burstActive,
  output logic [BURST_W-1:0]  burstCnt,
  output logic                ebusReset,
  output logic [1:0]          sourceSel,
  output logic [1:0]          rateSel,
  output logic [CDADR_W-1:0]  cramDiagAdr,
  output logic                parRegsReset,
  output logic                klEnable,
  output logic                ebusLoad
);

  localparam int unsigned CODE_W = 7;
  localparam int unsigned OPND_W = 6;

  localparam logic [CODE_W-1:0] F_STOP    = 7'o000;
  localparam logic [CODE_W-1:0] F_RUN     = 7'o001;
  localparam logic [CODE_W-1:0] F_STEP    = 7'o002;
  localparam logic [CODE_W-1:0] F_BURST   = 7'o004;
  localparam logic [CODE_W-1:0] F_RST_CLR = 7'o006;
  localparam logic [CODE_W-1:0] F_RST_SET = 7'o007;
  localparam logic [CODE_W-1:0] F_CNT_LO  = 7'o042;
  localparam logic [CODE_W-1:0] F_CNT_HI  = 7'o043;
  localparam logic [CODE_W-1:0] F_SRC     = 7'o044;
  localparam logic [CODE_W-1:0] F_PAR     = 7'o046;
  localparam logic [CODE_W-1:0] F_ADR_LO  = 7'o051;
  localparam logic [CODE_W-1:0] F_ADR_HI  = 7'o052;
  localparam logic [CODE_W-1:0] F_KL      = 7'o067;
  localparam logic [CODE_W-1:0] F_LOAD    = 7'o076;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state;
  logic              strobe_prev;
  logic              step_pulse;
  logic [CODE_W-1:0] code;
  logic [OPND_W-1:0] opnd;
  logic              strobe_rise;
  logic              unused_data;

  // Only EBUS data[30:35] is ever used as an operand.
  assign unused_data = ^bus.ebusData[0:29];

  assign strobe_rise = bus.diagStrobe & ~strobe_prev;

  // EBOX clock enable is the OR of the three registered enable sources.
  assign clkEn = clkRun | burstActive | step_pulse;

  // Function FSM, burst counter and all CLK control registers.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state           <= S_IDLE;
      strobe_prev     <= 1'b0;
      step_pulse      <= 1'b0;
      code            <= '0;
      opnd            <= '0;
      clkRun          <= 1'b0;
      burstActive     <= 1'b0;
      burstCnt        <= '0;
      ebusReset       <= 1'b1;
      sourceSel       <= '0;
      rateSel         <= '0;
      cramDiagAdr     <= '0;
      parRegsReset    <= 1'b0;
      klEnable        <= 1'b0;
      ebusLoad        <= 1'b0;
      bus.funcAck     <= 1'b0;
      bus.funcIllegal <= 1'b0;
    end else begin
      strobe_prev  <= bus.diagStrobe;
      step_pulse   <= 1'b0;
      parRegsReset <= 1'b0;
      ebusLoad     <= 1'b0;
      bus.funcAck  <= 1'b0;

      // Burst: one enabled cycle per count, stopping as the count reaches 0.
      if (burstActive) begin
        if (burstCnt <= BURST_W'(1)) begin
          burstActive <= 1'b0;
          burstCnt    <= '0;
        end else begin
          burstCnt <= burstCnt - BURST_W'(1);
        end
      end

      unique case (state)
        S_IDLE: begin
          if (strobe_rise) begin
            if (bus.ds[0]) begin
              state <= S_HOLD;
            end else begin
              code  <= bus.ds;
              opnd  <= bus.ebusData[30:35];
              state <= S_EXEC;
            end
          end
        end

        S_EXEC: begin
          bus.funcAck <= 1'b1;
          state       <= S_HOLD;
          case (code)
            F_STOP: begin
              clkRun      <= 1'b0;
              burstActive <= 1'b0;
            end
            F_RUN:     clkRun <= 1'b1;
            F_STEP:    if (!clkRun) step_pulse <= 1'b1;
            F_BURST: begin
              // An already running burst is left alone so it cannot restart at 0.
              if ((burstCnt != '0) && !clkRun && !burstActive) burstActive <= 1'b1;
            end
            F_RST_CLR: ebusReset <= 1'b0;
            F_RST_SET: ebusReset <= 1'b1;
            F_CNT_LO:  if (!burstActive) burstCnt[3:0] <= opnd[3:0];
            F_CNT_HI:  if (!burstActive) burstCnt[BURST_W-1:4] <= opnd[BURST_W-5:0];
            F_SRC: begin
              sourceSel <= opnd[3:2];
              rateSel   <= opnd[1:0];
            end
            F_PAR:     parRegsReset <= 1'b1;
            F_ADR_LO:  cramDiagAdr[5:0] <= opnd;
            F_ADR_HI:  cramDiagAdr[CDADR_W-1:6] <= opnd[CDADR_W-7:0];
            F_KL:      klEnable <= 1'b1;
            F_LOAD:    ebusLoad <= 1'b1;
            default:   bus.funcIllegal <= 1'b1;
          endcase
        end

        S_HOLD: begin
          if (!bus.diagStrobe) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_diag_responder.sv
// Directed bench for clk_diag_responder: a vector table for single functions
// plus hand-written sequences for burst, step, held strobe and reset aborts.
module tb_clk_diag_responder;

  logic       clk;
  logic       CROBAR;
  logic       clkEn, clkRun, burstActive, ebusReset;
  logic [7:0] burstCnt;
  logic [1:0] sourceSel, rateSel;
  logic [10:0] cramDiagAdr;
  logic       parRegsReset, klEnable, ebusLoad;

  clk_diag_responder_if bus ();

  clk_diag_responder #(.BURST_W(8), .CDADR_W(11)) dut (
    .clk          (clk),
    .CROBAR       (CROBAR),
    .bus          (bus),
    .clkEn        (clkEn),
    .clkRun       (clkRun),
    .burstActive  (burstActive),
    .burstCnt     (burstCnt),
    .ebusReset    (ebusReset),
    .sourceSel    (sourceSel),
    .rateSel      (rateSel),
    .cramDiagAdr  (cramDiagAdr),
    .parRegsReset (parRegsReset),
    .klEnable     (klEnable),
    .ebusLoad     (ebusLoad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  ds;
    logic [35:0] data;
    logic        ack;
    logic        par;
    logic        load;
    logic        run;
    logic        erst;
    logic [1:0]  src;
    logic [1:0]  rate;
    logic [10:0] cdadr;
    logic        kl;
    logic        ill;
    logic [7:0]  bcnt;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tv [NVEC];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Raise the strobe at the current negedge, drop it after 'hold' samples,
  // and sample ack/enable on each of the next 'window' negedges.
  task automatic fire(input logic [6:0] code, input logic [35:0] data,
                      input int hold, input int window,
                      output int acks, output int ens,
                      output logic ack2, output logic par2, output logic load2);
    bus.ds         = code;
    bus.ebusData   = data;
    bus.diagStrobe = 1'b1;
    acks = 0; ens = 0; ack2 = 1'b0; par2 = 1'b0; load2 = 1'b0;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      acks += int'(bus.funcAck);
      ens  += int'(clkEn);
      if (k == 2) begin
        ack2  = bus.funcAck;
        par2  = parRegsReset;
        load2 = ebusLoad;
      end
      if (k == hold) bus.diagStrobe = 1'b0;
    end
  endtask

  int   acks, ens;
  logic ack2, par2, load2;

  initial begin
    //          ds      data            ack   par   load  run   erst  src   rate  cdadr    kl    ill   bcnt
    tv[0]  = '{7'o006, 36'h000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 11'h000, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{7'o052, 36'hFFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 11'h7C0, 1'b0, 1'b0, 8'h00};
    tv[2]  = '{7'o051, 36'h0000000FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 11'h7FF, 1'b0, 1'b0, 8'h00};
    tv[3]  = '{7'o044, 36'hABCDEF12B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 11'h7FF, 1'b0, 1'b0, 8'h00};
    tv[4]  = '{7'o046, 36'h000000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 11'h7FF, 1'b0, 1'b0, 8'h00};
    tv[5]  = '{7'o076, 36'h000000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd3, 11'h7FF, 1'b0, 1'b0, 8'h00};
    tv[6]  = '{7'o067, 36'h000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 11'h7FF, 1'b1, 1'b0, 8'h00};
    tv[7]  = '{7'o043, 36'h000000005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 11'h7FF, 1'b1, 1'b0, 8'h50};
    tv[8]  = '{7'o042, 36'h00000000A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 11'h7FF, 1'b1, 1'b0, 8'h5A};
    tv[9]  = '{7'o001, 36'h000000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 11'h7FF, 1'b1, 1'b0, 8'h5A};
    tv[10] = '{7'o101, 36'hFFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 11'h7FF, 1'b1, 1'b0, 8'h5A};
    tv[11] = '{7'o000, 36'h000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 11'h7FF, 1'b1, 1'b0, 8'h5A};
    tv[12] = '{7'o007, 36'h000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3, 11'h7FF, 1'b1, 1'b0, 8'h5A};
    tv[13] = '{7'o013, 36'h000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3, 11'h7FF, 1'b1, 1'b1, 8'h5A};
    tv[14] = '{7'o005, 36'h000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3, 11'h7FF, 1'b1, 1'b1, 8'h5A};
    tv[15] = '{7'o044, 36'h000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 11'h7FF, 1'b1, 1'b1, 8'h5A};

    bus.diagStrobe = 1'b0;
    bus.ds         = '0;
    bus.ebusData   = '0;
    CROBAR         = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst ebusReset", ebusReset, 1);
    chk("rst clkEn", clkEn, 0);
    chk("rst clkRun", clkRun, 0);
    chk("rst burstActive", burstActive, 0);
    chk("rst burstCnt", burstCnt, 0);
    chk("rst sel", {sourceSel, rateSel}, 0);
    chk("rst cramDiagAdr", cramDiagAdr, 0);
    chk("rst pulses", {parRegsReset, ebusLoad, bus.funcAck}, 0);
    chk("rst kl/ill", {klEnable, bus.funcIllegal}, 0);
    CROBAR = 1'b0;
    @(negedge clk);

    // Single-function vector table
    for (int i = 0; i < NVEC; i++) begin
      fire(tv[i].ds, tv[i].data, 2, 4, acks, ens, ack2, par2, load2);
      chk($sformatf("v%0d ack_at_2clk", i), ack2, tv[i].ack);
      chk($sformatf("v%0d ack_count", i), acks, tv[i].ack);
      chk($sformatf("v%0d parRegsReset", i), par2, tv[i].par);
      chk($sformatf("v%0d ebusLoad", i), load2, tv[i].load);
      chk($sformatf("v%0d clkRun", i), clkRun, tv[i].run);
      chk($sformatf("v%0d ebusReset", i), ebusReset, tv[i].erst);
      chk($sformatf("v%0d sourceSel", i), sourceSel, tv[i].src);
      chk($sformatf("v%0d rateSel", i), rateSel, tv[i].rate);
      chk($sformatf("v%0d cramDiagAdr", i), cramDiagAdr, tv[i].cdadr);
      chk($sformatf("v%0d klEnable", i), klEnable, tv[i].kl);
      chk($sformatf("v%0d funcIllegal", i), bus.funcIllegal, tv[i].ill);
      chk($sformatf("v%0d burstCnt", i), burstCnt, tv[i].bcnt);
    end

    // Burst of 0x5A: exactly 90 enabled cycles, then idle at 0
    fire(7'o004, 36'h0, 2, 120, acks, ens, ack2, par2, load2);
    chk("burst ack", acks, 1);
    chk("burst clkEn cycles", ens, 90);
    chk("burst end active", burstActive, 0);
    chk("burst end cnt", burstCnt, 0);

    // Burst with zero count does nothing
    fire(7'o004, 36'h0, 2, 6, acks, ens, ack2, par2, load2);
    chk("burst0 clkEn cycles", ens, 0);

    // Step is ignored while running, single cycle when stopped
    fire(7'o001, 36'h0, 2, 4, acks, ens, ack2, par2, load2);
    chk("run clkRun", clkRun, 1);
    fire(7'o002, 36'h0, 2, 4, acks, ens, ack2, par2, load2);
    chk("step-while-run clkRun", clkRun, 1);
    chk("step-while-run ack", acks, 1);
    fire(7'o000, 36'h0, 2, 4, acks, ens, ack2, par2, load2);
    chk("stop clkEn cycles", ens, 1);
    fire(7'o002, 36'h0, 2, 4, acks, ens, ack2, par2, load2);
    chk("step clkEn cycles", ens, 1);
    chk("step clkEn at 2clk", ack2 & clkRun, 0);

    // Held strobe acts once; a ds[0]=1 edge is ignored
    fire(7'o001, 36'h0, 20, 22, acks, ens, ack2, par2, load2);
    chk("held ack count", acks, 1);
    chk("held clkRun", clkRun, 1);
    fire(7'o100, 36'h0, 2, 4, acks, ens, ack2, par2, load2);
    chk("foreign ack count", acks, 0);
    chk("foreign clkRun", clkRun, 1);
    fire(7'o000, 36'h0, 2, 4, acks, ens, ack2, par2, load2);
    chk("stop2 clkRun", clkRun, 0);

    // Load 200, start burst, reset after 10 cycles
    fire(7'o043, 36'h00000000C, 2, 4, acks, ens, ack2, par2, load2);
    fire(7'o042, 36'h000000008, 2, 4, acks, ens, ack2, par2, load2);
    chk("cnt200 load", burstCnt, 200);
    fire(7'o004, 36'h0, 2, 10, acks, ens, ack2, par2, load2);
    chk("mid-burst active", burstActive, 1);
    chk("mid-burst cnt", burstCnt, 192);
    chk("mid-burst clkEn cycles", ens, 9);
    CROBAR = 1'b1;
    @(negedge clk);
    chk("abort burstActive", burstActive, 0);
    chk("abort burstCnt", burstCnt, 0);
    chk("abort clkEn", clkEn, 0);
    chk("abort ebusReset", ebusReset, 1);
    chk("abort funcIllegal", bus.funcIllegal, 0);
    CROBAR = 1'b0;
    @(negedge clk);

    // Reset while a function is in EXEC: no ack, no effect
    bus.ds = 7'o001; bus.ebusData = '0; bus.diagStrobe = 1'b1;
    @(negedge clk);
    CROBAR = 1'b1;
    bus.diagStrobe = 1'b0;
    @(negedge clk);
    chk("exec-abort funcAck", bus.funcAck, 0);
    chk("exec-abort clkRun", clkRun, 0);
    CROBAR = 1'b0;
    repeat (2) @(negedge clk);
    chk("post-abort funcAck", bus.funcAck, 0);
    chk("post-abort clkRun", clkRun, 0);

    // Illegal code is sticky
    fire(7'o013, 36'h0, 2, 4, acks, ens, ack2, par2, load2);
    chk("illegal set", bus.funcIllegal, 1);
    chk("illegal ack", acks, 1);
    fire(7'o001, 36'h0, 2, 4, acks, ens, ack2, par2, load2);
    chk("illegal sticky", bus.funcIllegal, 1);
    chk("illegal then run", clkRun, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
